// File: rtl/sync_pkg.sv
// Shared definitions for the synchronized frequency meter: FSM state encoding,
// output byte select codes and status byte layout.
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] SEL_PER_LO = 3'd0;
    localparam logic [2:0] SEL_PER_HI = 3'd1;
    localparam logic [2:0] SEL_STB    = 3'd2;
    localparam logic [2:0] SEL_STATUS = 3'd3;
    localparam logic [2:0] SEL_EDGES  = 3'd4;

    localparam int ST_VALID_BIT   = 7;
    localparam int ST_BUSY_BIT    = 6;
    localparam int ST_TIMEOUT_BIT = 5;
    localparam int ST_SAT_BIT     = 4;

    function automatic logic [7:0] status_byte(input logic valid, input logic busy,
                                               input logic timeout, input logic sat,
                                               input state_t st);
        logic [7:0] b;
        b = {6'b0, st};
        b[ST_VALID_BIT]   = valid;
        b[ST_BUSY_BIT]    = busy;
        b[ST_TIMEOUT_BIT] = timeout;
        b[ST_SAT_BIT]     = sat;
        return b;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector on an already-synchronized level: one delay register,
// combinational rise output valid in the cycle the new level is first seen.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic level_d;

    always_ff @(posedge clk) begin
        if (rst) level_d <= 1'b0;
        else     level_d <= level;
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/sync_freq_meter.sv
// Measures clk cycles across N_EDGES clk_2 periods per strobe, with timeout,
// saturation and a strobe event count, all readable through a registered byte mux.
module sync_freq_meter
    import sync_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int N_EDGES   = 8,
    parameter int TO_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       clk2_s,
    input  logic       stb_s,
    input  logic [2:0] sel,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy
);
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    localparam logic [CNT_W-1:0] PER_MAX   = {CNT_W{1'b1}};
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);
    localparam logic [7:0]       EDGE_LAST = 8'(N_EDGES - 1);

    state_t           state, state_nxt;
    logic             clk2_rise, stb_rise;
    logic [CNT_W-1:0] period;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       edge_cnt;
    logic [7:0]       stb_cnt;
    logic             timeout, sat;
    logic             to_last, edge_last;
    logic [15:0]      per_ext;
    logic [7:0]       mux_byte;

    edge_det u_clk2_det (.clk(clk), .rst(rst), .level(clk2_s), .rise(clk2_rise));
    edge_det u_stb_det  (.clk(clk), .rst(rst), .level(stb_s),  .rise(stb_rise));

    assign to_last   = (to_cnt == TO_LAST);
    assign edge_last = (edge_cnt == EDGE_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A rise on the final edge takes priority over an expiring timeout.
    always_comb begin
        state_nxt = state;
        if (!ena) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (stb_rise) state_nxt = ARM;
                ARM:     if (clk2_rise) state_nxt = MEASURE;
                         else if (to_last) state_nxt = DONE;
                MEASURE: if (clk2_rise ? edge_last : to_last) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == ARM) || (state == MEASURE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period   <= '0;
            to_cnt   <= '0;
            edge_cnt <= '0;
            stb_cnt  <= '0;
            timeout  <= 1'b0;
            sat      <= 1'b0;
            valid    <= 1'b0;
        end else if (ena) begin
            if (stb_rise) stb_cnt <= stb_cnt + 8'd1;
            unique case (state)
                IDLE: if (stb_rise) begin
                    period   <= '0;
                    to_cnt   <= '0;
                    edge_cnt <= '0;
                    timeout  <= 1'b0;
                    sat      <= 1'b0;
                    valid    <= 1'b0;
                end
                ARM: begin
                    if (clk2_rise) begin
                        period   <= '0;
                        edge_cnt <= '0;
                        to_cnt   <= '0;
                    end else if (to_last) begin
                        timeout <= 1'b1;
                        valid   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                MEASURE: begin
                    if (period == PER_MAX) sat <= 1'b1;
                    else                   period <= period + CNT_W'(1);
                    if (clk2_rise) begin
                        edge_cnt <= edge_cnt + 8'd1;
                        to_cnt   <= '0;
                        if (edge_last) valid <= 1'b1;
                    end else if (to_last) begin
                        timeout <= 1'b1;
                        valid   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DONE: ;
            endcase
        end
    end

    assign per_ext = 16'(period);

    always_comb begin
        mux_byte = 8'h00;
        case (sel)
            SEL_PER_LO: mux_byte = per_ext[7:0];
            SEL_PER_HI: mux_byte = per_ext[15:8];
            SEL_STB:    mux_byte = stb_cnt;
            SEL_STATUS: mux_byte = status_byte(valid, busy, timeout, sat, state);
            SEL_EDGES:  mux_byte = edge_cnt;
            default:    mux_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) data_out <= 8'h00;
        else     data_out <= mux_byte;
    end

endmodule

// File: tb/tb_sync_freq_meter.sv
// Scoreboard bench for sync_freq_meter: a 16-bit and an 8-bit counter instance
// share stimulus; results are read back through sel after each completion.
module tb_sync_freq_meter;
    localparam int N_EDGES = 8;

    logic       clk = 1'b0;
    logic       rst, ena, clk2_s, stb_s;
    logic [2:0] sel;
    logic [7:0] data_out16, data_out8;
    logic       valid16, busy16, valid8, busy8;

    sync_freq_meter #(.CNT_W(16), .N_EDGES(N_EDGES), .TO_CYCLES(1023)) u_dut16 (
        .clk(clk), .rst(rst), .ena(ena), .clk2_s(clk2_s), .stb_s(stb_s), .sel(sel),
        .data_out(data_out16), .valid(valid16), .busy(busy16));

    sync_freq_meter #(.CNT_W(8), .N_EDGES(N_EDGES), .TO_CYCLES(1023)) u_dut8 (
        .clk(clk), .rst(rst), .ena(ena), .clk2_s(clk2_s), .stb_s(stb_s), .sel(sel),
        .data_out(data_out8), .valid(valid8), .busy(busy8));

    always #5 clk = ~clk;

    typedef struct {
        int per16;
        int per8;
        bit sat16;
        bit sat8;
        bit to;
        int edges;
        int stb;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   pushed = 0;
    int   checked = 0;
    int   half = 0;
    int   stb_model = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: an undisturbed measurement of clk_2 with half-period h spans
    // N_EDGES*2*h clk cycles; h==0 means clk_2 never rises, so it times out in ARM.
    function automatic exp_t model(input int h, input int stbc);
        exp_t e;
        int   full;
        full = N_EDGES * 2 * h;
        e.to    = (h == 0);
        e.per16 = (full > 65535) ? 65535 : full;
        e.per8  = (full > 255) ? 255 : full;
        e.sat16 = (full > 65535);
        e.sat8  = (full > 255);
        e.edges = (h == 0) ? -1 : N_EDGES;
        e.stb   = stbc % 256;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // clk_2 source: toggles every `half` clk cycles, held low when half is 0.
    initial begin
        int cnt;
        cnt = 0;
        clk2_s = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (half == 0) begin
                clk2_s = 1'b0;
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= half) begin
                    cnt = 0;
                    clk2_s = ~clk2_s;
                end
            end
        end
    end

    task automatic pulse_stb();
        stb_s = 1'b1;
        tick(2);
        stb_s = 1'b0;
        tick(2);
        if (ena) stb_model++;
    endtask

    task automatic set_half(input int h);
        half = h;
        tick(4 * h + 6);
    endtask

    task automatic wait_checked();
        int n;
        n = 0;
        while (checked < pushed && n < 4000) begin
            tick(1);
            n++;
        end
        if (checked < pushed) begin
            total++;
            bad++;
            $display("FAIL wait_result: checked=%0d required=%0d", checked, pushed);
            sb_q.delete();
            checked = pushed;
        end
    endtask

    task automatic run_meas(input int h, input int extra);
        exp_t e;
        set_half(h);
        e = model(h, stb_model + 1 + extra);
        sb_q.push_back(e);
        pushed++;
        pulse_stb();
        repeat (extra) pulse_stb();
        wait_checked();
    endtask

    // Monitor: on each completion, sweep sel through every code and compare.
    initial begin
        logic pv;
        exp_t e;
        logic [7:0] x16, x8;
        pv = 1'b0;
        sel = 3'd0;
        forever begin
            @(negedge clk);
            if (valid16 && !pv) begin
                check("valid8", valid8, 1'b1);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got valid=1 required no result pending");
                end else begin
                    e = sb_q.pop_front();
                    for (int s = 0; s < 8; s++) begin
                        sel = 3'(s);
                        @(posedge clk);
                        @(negedge clk);
                        case (s)
                            0: begin x16 = 8'(e.per16);      x8 = 8'(e.per8); end
                            1: begin x16 = 8'(e.per16 >> 8); x8 = 8'h00; end
                            2: begin x16 = 8'(e.stb);        x8 = 8'(e.stb); end
                            3: begin
                                x16 = 8'h80 | (e.to ? 8'h20 : 8'h00) | (e.sat16 ? 8'h10 : 8'h00);
                                x8  = 8'h80 | (e.to ? 8'h20 : 8'h00) | (e.sat8  ? 8'h10 : 8'h00);
                            end
                            4: begin x16 = 8'(e.edges);      x8 = 8'(e.edges); end
                            default: begin x16 = 8'h00;      x8 = 8'h00; end
                        endcase
                        if (!(s == 4 && e.edges < 0)) begin
                            check($sformatf("sel%0d_w16", s), data_out16, x16);
                            check($sformatf("sel%0d_w8", s), data_out8, x8);
                        end
                    end
                    sel = 3'd0;
                    checked++;
                end
            end
            pv = valid16;
        end
    end

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        stb_s = 1'b0;
        tick(3);
        check("rst_valid", valid16, 1'b0);
        check("rst_busy", busy16, 1'b0);
        check("rst_data16", data_out16, 8'h00);
        check("rst_data8", data_out8, 8'h00);
        rst = 1'b0;
        stb_model = 0;
        tick(2);

        run_meas(5, 0);
        run_meas(0, 0);
        run_meas(5, 3);
        run_meas(20, 0);

        // Reset in the middle of a measurement.
        set_half(5);
        pulse_stb();
        tick(25);
        check("mid_busy", busy16, 1'b1);
        rst = 1'b1;
        tick(1);
        check("abort_busy", busy16, 1'b0);
        check("abort_valid", valid16, 1'b0);
        check("abort_data16", data_out16, 8'h00);
        check("abort_data8", data_out8, 8'h00);
        rst = 1'b0;
        stb_model = 0;
        tick(2);
        run_meas(5, 0);

        // Enable dropped in the middle of a measurement; strobes while disabled.
        set_half(5);
        pulse_stb();
        tick(25);
        check("ena_mid_busy", busy16, 1'b1);
        ena = 1'b0;
        tick(1);
        check("ena_off_busy", busy16, 1'b0);
        check("ena_off_valid", valid16, 1'b0);
        pulse_stb();
        pulse_stb();
        check("ena_off_idle", busy16, 1'b0);
        ena = 1'b1;
        tick(2);
        run_meas(7, 1);

        repeat (8) run_meas(int'($urandom_range(2, 25)), int'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish required finish before 5ms");
        $fatal(1, "watchdog");
    end

endmodule
